// File: rtl/car_sim_pkg.sv
// Shared definitions for the car simulator detector path.
// Detector width and bit order are common to the conditioner and the controller.
package car_sim_pkg;

    localparam int DETECTOR_W = 4;

    // Bit positions of each obstacle detector within the vector
    localparam int DET_LEFT  = 0;
    localparam int DET_FRONT = 1;
    localparam int DET_RIGHT = 2;
    localparam int DET_BACK  = 3;

    typedef logic [DETECTOR_W-1:0] det_vec_t;

    // Saturating 8-bit add used for diagnostic counters
    function automatic logic [7:0] sat_add8(input logic [7:0] a, input logic [7:0] b);
        logic [8:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[8] ? 8'hFF : s[7:0];
    endfunction

endpackage

// File: rtl/debounce_channel.sv
// One detector line: two-flop synchroniser followed by a debounce counter.
// Flags the edge where the filtered level updates and the edge where a glitch is rejected.
module debounce_channel #(
    parameter int   DEBOUNCE_CYCLES = 3,
    parameter logic RESET_BIT       = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic enable,
    input  logic raw,
    output logic level,
    output logic update,
    output logic glitch,
    output logic busy
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          s1;
    logic          s2;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_next;

    // Synchroniser keeps sampling even while the filter is disabled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= RESET_BIT;
            s2 <= RESET_BIT;
        end else begin
            s1 <= raw;
            s2 <= s1;
        end
    end

    // Debounce decision: accept after enough mismatches, count a glitch on early match
    always_comb begin
        update   = 1'b0;
        glitch   = 1'b0;
        cnt_next = cnt;
        if (!enable) begin
            cnt_next = '0;
        end else if (s2 != level) begin
            if (cnt == LAST) begin
                update   = 1'b1;
                cnt_next = '0;
            end else begin
                cnt_next = cnt + 1'b1;
            end
        end else if (cnt != '0) begin
            glitch   = 1'b1;
            cnt_next = '0;
        end
    end

    assign busy = (cnt_next != '0);

    // Counter and filtered level registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= '0;
            level <= RESET_BIT;
        end else begin
            cnt <= cnt_next;
            if (update) begin
                level <= s2;
            end
        end
    end

endmodule

// File: rtl/detector_conditioner.sv
// Conditions the raw obstacle-detector lines for the auto-driving controller.
// Debounces each line, pulses on changes, reports settling and counts rejected glitches.
module detector_conditioner
    import car_sim_pkg::*;
#(
    parameter int               WIDTH           = DETECTOR_W,
    parameter int               DEBOUNCE_CYCLES = 3,
    parameter int               SETTLE_CYCLES   = 5,
    parameter logic [WIDTH-1:0] RESET_VALUE     = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic [WIDTH-1:0] detector_raw,
    input  logic             glitch_clr,
    output logic [WIDTH-1:0] detector,
    output logic             detector_changed,
    output logic [WIDTH-1:0] changed_mask,
    output logic             settled,
    output logic [7:0]       glitch_cnt
);

    localparam int GW = $clog2(WIDTH + 1);
    localparam int SW = $clog2(SETTLE_CYCLES + 1);
    localparam logic [SW-1:0] SMAX = SW'(SETTLE_CYCLES);

    logic [WIDTH-1:0] upd;
    logic [WIDTH-1:0] glt;
    logic [WIDTH-1:0] busy;
    logic [GW-1:0]    gsum;
    logic [7:0]       glitch_next;
    logic [SW-1:0]    settle_cnt;
    logic [SW-1:0]    settle_next;

    for (genvar i = 0; i < WIDTH; i++) begin : g_line
        debounce_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .RESET_BIT       (RESET_VALUE[i])
        ) u_chan (
            .clk    (clk),
            .rst_n  (rst_n),
            .enable (enable),
            .raw    (detector_raw[i]),
            .level  (detector[i]),
            .update (upd[i]),
            .glitch (glt[i]),
            .busy   (busy[i])
        );
    end

    // Number of lines rejecting a glitch on this edge
    always_comb begin
        gsum = '0;
        for (int i = 0; i < WIDTH; i++) begin
            gsum = gsum + GW'(glt[i]);
        end
    end

    // Glitch counter: clear wins, otherwise saturating accumulate
    always_comb begin
        glitch_next = sat_add8(glitch_cnt, 8'(gsum));
        if (glitch_clr) begin
            glitch_next = '0;
        end
    end

    // Settle counter restarts whenever any line is changing or being filtered
    always_comb begin
        settle_next = settle_cnt;
        if (!enable || (|upd) || (|busy)) begin
            settle_next = '0;
        end else if (settle_cnt != SMAX) begin
            settle_next = settle_cnt + 1'b1;
        end
    end

    // Registered pulse, mask, settled flag and diagnostic counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            detector_changed <= 1'b0;
            changed_mask     <= '0;
            settled          <= 1'b0;
            settle_cnt       <= '0;
            glitch_cnt       <= '0;
        end else begin
            detector_changed <= |upd;
            changed_mask     <= upd;
            settled          <= (settle_next == SMAX);
            settle_cnt       <= settle_next;
            glitch_cnt       <= glitch_next;
        end
    end

endmodule

// File: tb/tb_detector_conditioner.sv
// Scoreboard bench for detector_conditioner.
// Expected change events are queued at stimulus time and matched when the pulse appears.
module tb_detector_conditioner;

    logic       clk;
    logic       rst_n;
    logic       enable;
    logic [3:0] detector_raw;
    logic       glitch_clr;
    logic [3:0] detector;
    logic       detector_changed;
    logic [3:0] changed_mask;
    logic       settled;
    logic [7:0] glitch_cnt;

    typedef struct {
        logic [3:0] det;
        logic [3:0] mask;
        int         edge_n;
    } exp_t;

    exp_t sb[$];
    int   cyc;
    int   n_checks;
    int   n_fail;

    detector_conditioner dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .enable           (enable),
        .detector_raw     (detector_raw),
        .glitch_clr       (glitch_clr),
        .detector         (detector),
        .detector_changed (detector_changed),
        .changed_mask     (changed_mask),
        .settled          (settled),
        .glitch_cnt       (glitch_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        cyc = 0;
        forever begin
            @(posedge clk);
            cyc = cyc + 1;
        end
    end

    task automatic check(input string tag, input int unsigned obs, input int unsigned exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Returns just after posedge n (drive point)
    task automatic at(input int n);
        while (cyc < n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Returns at the falling edge following posedge n (sample point)
    task automatic sample(input int n);
        at(n);
        @(negedge clk);
    endtask

    task automatic expect_change(input logic [3:0] d, input logic [3:0] m, input int e);
        exp_t x;
        x.det    = d;
        x.mask   = m;
        x.edge_n = e;
        sb.push_back(x);
    endtask

    // Pop and compare on every change pulse
    always @(negedge clk) begin
        if (rst_n && detector_changed) begin
            if (sb.size() == 0) begin
                check("unexp_pulse", detector_changed, 0);
            end else begin
                exp_t x;
                x = sb.pop_front();
                check("pulse_det", detector, x.det);
                check("pulse_mask", changed_mask, x.mask);
                check("pulse_edge", cyc, x.edge_n);
            end
        end
    end

    initial begin
        #20000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks     = 0;
        n_fail       = 0;
        rst_n        = 1'b0;
        enable       = 1'b1;
        glitch_clr   = 1'b0;
        detector_raw = 4'b1111;

        sample(3);
        check("rst_det", detector, 4'b0000);
        check("rst_settled", settled, 0);
        check("rst_glitch", glitch_cnt, 0);
        check("rst_changed", detector_changed, 0);
        check("rst_mask", changed_mask, 0);
        detector_raw = 4'b0000;
        at(4);
        rst_n = 1'b1;
        sample(10);
        check("post_rst_settled", settled, 1);
        check("post_rst_det", detector, 4'b0000);

        at(12);
        detector_raw = 4'b0101;
        expect_change(4'b0101, 4'b0101, 17);
        sample(16);
        check("step_early", detector, 4'b0000);
        sample(17);
        check("step_settled_low", settled, 0);
        sample(18);
        check("step_pulse_drop", detector_changed, 0);
        check("step_mask_drop", changed_mask, 0);
        sample(21);
        check("step_settle_wait", settled, 0);
        sample(22);
        check("step_settle_rise", settled, 1);

        at(24);
        detector_raw = 4'b0111;
        at(26);
        detector_raw = 4'b0101;
        sample(27);
        check("glitch_settle_drop", settled, 0);
        sample(29);
        check("glitch_cnt1", glitch_cnt, 1);
        check("glitch_det", detector, 4'b0101);
        sample(32);
        check("glitch_settle_wait", settled, 0);
        sample(33);
        check("glitch_settle_back", settled, 1);

        at(36);
        detector_raw = 4'b1111;
        expect_change(4'b1111, 4'b1010, 41);
        at(44);
        detector_raw = 4'b1000;
        at(46);
        detector_raw = 4'b1111;
        sample(50);
        check("glitch3_cnt", glitch_cnt, 4);
        check("glitch3_det", detector, 4'b1111);

        for (int i = 0; i < 75; i++) begin
            int base;
            base = 52 + 6 * i;
            at(base);
            detector_raw = 4'b0000;
            at(base + 2);
            detector_raw = 4'b1111;
            if (i == 9) begin
                sample(base + 6);
                check("sat_mid", glitch_cnt, 44);
            end
        end
        sample(502);
        check("sat_255", glitch_cnt, 255);
        check("sat_det", detector, 4'b1111);

        at(504);
        detector_raw = 4'b0000;
        at(506);
        detector_raw = 4'b1111;
        at(508);
        glitch_clr = 1'b1;
        at(509);
        glitch_clr = 1'b0;
        sample(509);
        check("clr_prio", glitch_cnt, 0);
        at(512);
        detector_raw = 4'b1110;
        at(514);
        detector_raw = 4'b1111;
        sample(518);
        check("clr_then_inc", glitch_cnt, 1);

        at(520);
        detector_raw = 4'b0111;
        at(523);
        enable = 1'b0;
        sample(524);
        check("dis_settled", settled, 0);
        check("dis_det", detector, 4'b1111);
        check("dis_changed", detector_changed, 0);
        at(526);
        enable = 1'b1;
        expect_change(4'b0111, 4'b1000, 529);
        sample(528);
        check("reen_restart", detector, 4'b1111);
        sample(530);
        check("reen_glitch_hold", glitch_cnt, 1);

        at(532);
        detector_raw = 4'b1111;
        at(535);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_det", detector, 4'b0000);
        check("arst_changed", detector_changed, 0);
        check("arst_mask", changed_mask, 0);
        check("arst_settled", settled, 0);
        check("arst_glitch", glitch_cnt, 0);
        at(538);
        rst_n = 1'b1;
        expect_change(4'b1111, 4'b1111, 543);
        sample(545);
        check("arst_recover", detector, 4'b1111);
        check("sb_empty", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
